// File: rtl/apb_keyed_regfile_if.sv
// APB4 completer-side bundle for the keyed register file.
// Clock and reset stay as plain ports on the modules.
interface apb_keyed_regfile_if #(
   parameter int unsigned ADDR_W = 8
) ();
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_keyed_regfile.sv
// APB4 register file with byte strobes, W1C status, masked irq and CFG/START
// writes guarded by a two-word key unlock that relocks on timeout.
//
// state    | meaning
// LOCKED   | CFG writes and START rejected; waiting for KEY1
// ARMED    | KEY1 seen; next committed write must be KEY2
// UNLOCKED | CFG/START allowed; timer counts down to auto-relock
module apb_keyed_regfile #(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned NUM_CFG   = 4,
   parameter logic [31:0] CFG_RESET = 32'h0000_0000,
   parameter logic [31:0] KEY1      = 32'hDEAD_BEEF,
   parameter logic [31:0] KEY2      = 32'hC0DE_F00D,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   apb_keyed_regfile_if.slave     apb,
   input  logic [31:0]            hw_event,
   output logic [32*NUM_CFG-1:0]  cfg_out,
   output logic                   ctrl_enable,
   output logic                   start_pulse,
   output logic [1:0]             lock_state,
   output logic                   irq
);
   typedef enum logic [1:0] {
      LOCKED   = 2'd0,
      ARMED    = 2'd1,
      UNLOCKED = 2'd2
   } lock_t;

   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT);

   lock_t             state;
   logic [15:0]       timer;
   logic [31:0]       status_q;
   logic [31:0]       irq_mask_q;
   logic [31:0]       cfg_q [NUM_CFG];

   logic [ADDR_W-1:0] paddr;
   logic [ADDR_W-1:0] cfg_off;
   logic [ADDR_W-1:0] cfg_idx;
   logic              access, wr, rd;
   logic              hit_ctrl, hit_status, hit_mask, hit_key, hit_info, hit_cfg, mapped;
   logic              unlocked, start_req, err;
   logic              we_ctrl, we_status, we_mask, we_cfg, key_wr, key_full;
   logic [31:0]       bmask;
   logic [31:0]       rdata;

   assign paddr   = apb.paddr;
   assign access  = apb.psel & apb.penable;
   assign wr      = access & apb.pwrite;
   assign rd      = access & ~apb.pwrite;

   assign hit_ctrl   = (paddr == ADDR_W'(32'h00));
   assign hit_status = (paddr == ADDR_W'(32'h04));
   assign hit_mask   = (paddr == ADDR_W'(32'h08));
   assign hit_key    = (paddr == ADDR_W'(32'h0C));
   assign hit_info   = (paddr == ADDR_W'(32'h10));
   assign cfg_off    = paddr - ADDR_W'(32'h20);
   assign cfg_idx    = {2'b00, cfg_off[ADDR_W-1:2]};
   assign hit_cfg    = (paddr >= ADDR_W'(32'h20)) && (paddr[1:0] == 2'b00)
                       && (cfg_idx < ADDR_W'(NUM_CFG));
   assign mapped     = hit_ctrl | hit_status | hit_mask | hit_key | hit_info | hit_cfg;

   assign unlocked  = (state == UNLOCKED);
   assign start_req = hit_ctrl & apb.pstrb[0] & apb.pwdata[1];
   assign err       = access & (~mapped | (apb.pwrite & (hit_info
                        | (hit_cfg & ~unlocked) | (start_req & ~unlocked))));

   // A rejected START still lets ENABLE through, so CTRL commits regardless of err.
   assign we_ctrl   = wr & hit_ctrl;
   assign we_status = wr & hit_status;
   assign we_mask   = wr & hit_mask;
   assign we_cfg    = wr & hit_cfg & unlocked;
   assign key_wr    = wr & hit_key;
   assign key_full  = (apb.pstrb == 4'hF);

   assign bmask = {{8{apb.pstrb[3]}}, {8{apb.pstrb[2]}}, {8{apb.pstrb[1]}}, {8{apb.pstrb[0]}}};

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (hit_ctrl)   rdata = {31'b0, ctrl_enable};
         if (hit_status) rdata = status_q;
         if (hit_mask)   rdata = irq_mask_q;
         if (hit_info)   rdata = {timer, 14'b0, state};
         for (int i = 0; i < NUM_CFG; i++) begin
            if (hit_cfg && (cfg_idx == ADDR_W'(i))) rdata = cfg_q[i];
         end
      end
   end

   assign apb.prdata  = rdata;
   assign apb.pslverr = err;
   assign apb.pready  = 1'b1;
   assign lock_state  = state;

   for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
      assign cfg_out[32*g +: 32] = cfg_q[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOCKED;
         timer <= '0;
      end else begin
         case (state)
            LOCKED: begin
               if (key_wr && key_full && (apb.pwdata == KEY1)) state <= ARMED;
            end
            ARMED: begin
               if (key_wr) begin
                  if (key_full && (apb.pwdata == KEY2)) begin
                     state <= UNLOCKED;
                     timer <= TMO_LOAD;
                  end else begin
                     state <= LOCKED;
                  end
               end else if (wr && !err) begin
                  state <= LOCKED;
               end
            end
            UNLOCKED: begin
               if (key_wr) begin
                  state <= LOCKED;
                  timer <= '0;
               end else if (we_cfg) begin
                  timer <= TMO_LOAD;
               end else if (TMO_LOAD != 16'd0) begin
                  if (timer == 16'd1) begin
                     state <= LOCKED;
                     timer <= '0;
                  end else begin
                     timer <= timer - 16'd1;
                  end
               end
            end
            default: begin
               state <= LOCKED;
               timer <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_enable <= 1'b0;
         start_pulse <= 1'b0;
         status_q    <= '0;
         irq_mask_q  <= '0;
         irq         <= 1'b0;
         for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RESET;
      end else begin
         start_pulse <= we_ctrl & start_req & unlocked;
         if (we_ctrl && apb.pstrb[0]) ctrl_enable <= apb.pwdata[0];
         // hw_event is OR'd after the clear so a coincident set survives.
         status_q <= (status_q & ~(we_status ? (apb.pwdata & bmask) : 32'h0)) | hw_event;
         if (we_mask) irq_mask_q <= (irq_mask_q & ~bmask) | (apb.pwdata & bmask);
         for (int i = 0; i < NUM_CFG; i++) begin
            if (we_cfg && (cfg_idx == ADDR_W'(i)))
               cfg_q[i] <= (cfg_q[i] & ~bmask) | (apb.pwdata & bmask);
         end
         irq <= |(status_q & irq_mask_q);
      end
   end
endmodule
